// File: rtl/des_round_sequencer.sv
// Iterative DES round controller. Holds the L/R data halves and the C/D key
// schedule, steps 16 Feistel rounds through an external f-function path, and
// presents the swapped pre-output {R16,L16} to the FP back end.
module des_round_sequencer #(
    parameter int NUM_ROUNDS = 16,
    parameter int F_LATENCY  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_lr,
    input  logic [55:0] in_cd,
    output logic        f_start,
    output logic [31:0] f_r,
    output logic [47:0] f_subkey,
    input  logic [31:0] f_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_lr,
    output logic [3:0]  round,
    output logic        busy
);

    localparam int            WW         = (F_LATENCY > 0) ? $clog2(F_LATENCY + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST  = WW'(F_LATENCY);
    localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS - 1);

    // PC-2 selection, 1-based bit positions counted from the MSB of {C,D}.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   l, r;
    logic [27:0]   c, d;
    logic [WW-1:0] wcnt;
    logic          decrypt;
    logic [1:0]    run_shift;
    logic [27:0]   c_step, d_step;

    // Key-schedule rotation for schedule step k (1..16).
    function automatic logic [1:0] shift_amt(input logic [4:0] k);
        return (k == 5'd1 || k == 5'd2 || k == 5'd9 || k == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        for (int i = 0; i < 48; i++) k[47 - i] = cd[56 - PC2[i]];
        return k;
    endfunction

    // Rotation that moves C/D from this round's subkey to the next one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        run_shift = 2'd1;
        if (decrypt) run_shift = shift_amt(5'd16 - {1'b0, round});
        else         run_shift = shift_amt({1'b0, round} + 5'd2);
        c_step = decrypt ? ror28(c, run_shift) : rol28(c, run_shift);
        d_step = decrypt ? ror28(d, run_shift) : rol28(d, run_shift);
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_lr    = out_valid ? {r, l} : 64'd0;
    assign f_r       = r;
    assign f_subkey  = pc2({c, d});

    // Round sequencer: accept a job, run the Feistel rounds, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            l       <= '0;
            r       <= '0;
            c       <= '0;
            d       <= '0;
            wcnt    <= '0;
            round   <= '0;
            decrypt <= 1'b0;
            f_start <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            f_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= RUN;
                        l       <= in_lr[63:32];
                        r       <= in_lr[31:0];
                        decrypt <= in_decrypt;
                        // Decrypt starts from the unrotated CD, which equals CD16 and yields K16.
                        c       <= in_decrypt ? in_cd[55:28] : rol28(in_cd[55:28], 2'd1);
                        d       <= in_decrypt ? in_cd[27:0]  : rol28(in_cd[27:0], 2'd1);
                        round   <= '0;
                        wcnt    <= '0;
                        f_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (wcnt == WAIT_LAST) begin
                        l    <= r;
                        r    <= l ^ f_result;
                        wcnt <= '0;
                        if (round == LAST_ROUND) begin
                            // Final round: no further rotation, round saturates.
                            state <= DONE;
                        end else begin
                            round   <= round + 4'd1;
                            c       <= c_step;
                            d       <= d_step;
                            f_start <= 1'b1;
                        end
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Self-checking bench for des_round_sequencer. Two instances (F_LATENCY 0 and 2)
// are driven against a plain DES reference model that wraps IP/PC-1/FP and the
// s1..s8 f-function, plus the FIPS known-answer vector.
module tb_des_round_sequencer;

    localparam int NR = 16;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int S_T [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic        in_decrypt [2];
    logic [63:0] in_lr      [2];
    logic [55:0] in_cd      [2];
    logic        f_start    [2];
    logic [31:0] f_r        [2];
    logic [47:0] f_subkey   [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [63:0] out_lr     [2];
    logic [3:0]  round      [2];
    logic        busy       [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // ---------------- reference DES model ----------------
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63 - i] = x[64 - IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[64 - IP_T[i]] = x[63 - i];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] key);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55 - i] = key[64 - PC1_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rot_left(input logic [27:0] x, input int n);
        logic [55:0] t;
        t = {x, x} << n;
        return t[55:28];
    endfunction

    // Subkey K_n (n = 1..16): CD0 rotated by the cumulative shift count, then PC-2.
    function automatic logic [47:0] subkey(input logic [55:0] cd, input int n);
        int          tot;
        logic [55:0] rc;
        logic [47:0] k;
        tot = 0;
        for (int i = 0; i < n; i++) tot += SHIFTS[i];
        tot = tot % 28;
        rc = {rot_left(cd[55:28], tot), rot_left(cd[27:0], tot)};
        for (int i = 0; i < 48; i++) k[47 - i] = rc[56 - PC2_T[i]];
        return k;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] rr, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, y;
        logic [5:0]  b;
        int          row, col;
        for (int i = 0; i < 48; i++) x[47 - i] = rr[32 - E_T[i]];
        x = x ^ k;
        for (int bx = 0; bx < 8; bx++) begin
            b   = x[47 - 6 * bx -: 6];
            row = {b[5], b[0]};
            col = b[4:1];
            s[31 - 4 * bx -: 4] = 4'(S_T[bx * 64 + row * 16 + col]);
        end
        for (int i = 0; i < 32; i++) y[31 - i] = s[32 - P_T[i]];
        return y;
    endfunction

    // Pre-output {R16,L16} for an IP'd block and a PC-1'd key.
    function automatic logic [63:0] des_pre(input logic [63:0] lr, input logic [55:0] cd, input logic dec);
        logic [31:0] ll, rr, t;
        ll = lr[63:32];
        rr = lr[31:0];
        for (int i = 0; i < NR; i++) begin
            t  = rr;
            rr = ll ^ des_f(rr, subkey(cd, dec ? NR - i : i + 1));
            ll = t;
        end
        return {rr, ll};
    endfunction

    // ---------------- DUTs and external f-path stand-ins ----------------
    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] fres;
        int          fcnt = 0;

        des_round_sequencer #(.NUM_ROUNDS(NR), .F_LATENCY(2 * g)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_decrypt (in_decrypt[g]),
            .in_lr      (in_lr[g]),
            .in_cd      (in_cd[g]),
            .f_start    (f_start[g]),
            .f_r        (f_r[g]),
            .f_subkey   (f_subkey[g]),
            .f_result   (fres),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_lr     (out_lr[g]),
            .round      (round[g]),
            .busy       (busy[g])
        );

        // f(R,K) is only valid on the sample cycle of a round; other cycles carry noise.
        always @(negedge clk) begin
            if (f_start[g]) fcnt = 0;
            else            fcnt = fcnt + 1;
            fres = (fcnt == 2 * g) ? des_f(f_r[g], f_subkey[g]) : $urandom;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic input_noise(input int sel);
        in_valid[sel]   = 1'($urandom);
        in_decrypt[sel] = 1'($urandom);
        in_lr[sel]      = {$urandom, $urandom};
        in_cd[sel]      = 56'({$urandom, $urandom});
    endtask

    // One job: accept, per-round f-interface checks, latency, result, backpressure, release.
    task automatic run_job(input int sel, input logic [63:0] lr, input logic [55:0] cd,
                           input logic dec, input int hold, output logic [63:0] res);
        logic [63:0] want;
        logic [31:0] hr;
        logic [47:0] hk;
        int          cyc, lat, pulses, since;
        want   = des_pre(lr, cd, dec);
        lat    = 2 * sel;
        hr     = '0;
        hk     = '0;
        @(negedge clk);
        check("in_ready_idle", in_ready[sel], 1);
        in_valid[sel]   = 1'b1;
        in_lr[sel]      = lr;
        in_cd[sel]      = cd;
        in_decrypt[sel] = dec;
        out_ready[sel]  = 1'b0;
        @(negedge clk);
        check("busy_after_accept", busy[sel], 1);
        cyc = 0; pulses = 0; since = 0;
        while (!out_valid[sel] && cyc < 400) begin
            if (f_start[sel]) begin
                if (pulses > 0) check("f_start_spacing", since, lat + 1);
                check("round_idx", round[sel], pulses);
                check("f_subkey", f_subkey[sel], subkey(cd, dec ? NR - pulses : pulses + 1));
                hr = f_r[sel];
                hk = f_subkey[sel];
                pulses++;
                since = 0;
            end else begin
                check("f_r_stable", f_r[sel], hr);
                check("f_subkey_stable", f_subkey[sel], hk);
            end
            input_noise(sel);
            @(negedge clk);
            cyc++;
            since++;
        end
        check("latency", cyc, NR * (lat + 1));
        check("pulse_count", pulses, NR);
        check("out_lr", out_lr[sel], want);
        check("round_saturated", round[sel], NR - 1);
        res = out_lr[sel];
        for (int h = 0; h < hold; h++) begin
            check("bp_out_valid", out_valid[sel], 1);
            check("bp_in_ready", in_ready[sel], 0);
            check("bp_out_lr", out_lr[sel], want);
            input_noise(sel);
            @(negedge clk);
        end
        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b1;
        @(negedge clk);
        check("release_busy", busy[sel], 0);
        check("release_out_valid", out_valid[sel], 0);
        check("release_in_ready", in_ready[sel], 1);
        out_ready[sel] = 1'b0;
    endtask

    // Three jobs with in_valid and out_ready held high.
    task automatic run_b2b(input int sel);
        logic [63:0] lrs [3];
        logic [55:0] cds [3];
        logic        decs [3];
        int          acc_n, done_n, cyc, last_rise;
        for (int j = 0; j < 3; j++) begin
            lrs[j]  = {$urandom, $urandom};
            cds[j]  = 56'({$urandom, $urandom});
            decs[j] = 1'($urandom);
        end
        @(negedge clk);
        out_ready[sel] = 1'b1;
        acc_n = 0; done_n = 0; cyc = 0; last_rise = 0;
        while (done_n < 3 && cyc < 300) begin
            if (out_valid[sel]) begin
                check("b2b_out_lr", out_lr[sel], des_pre(lrs[done_n], cds[done_n], decs[done_n]));
                if (done_n > 0) check("b2b_result_spacing", cyc - last_rise, NR * (2 * sel + 1) + 2);
                last_rise = cyc;
                done_n++;
            end
            if (acc_n < 3) begin
                in_valid[sel]   = 1'b1;
                in_lr[sel]      = lrs[acc_n];
                in_cd[sel]      = cds[acc_n];
                in_decrypt[sel] = decs[acc_n];
                if (in_ready[sel]) begin
                    if (acc_n > 0) check("b2b_accept_gap", cyc - last_rise, 1);
                    acc_n++;
                end
            end else begin
                in_valid[sel] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b_jobs_done", done_n, 3);
        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag, input int sel);
        check({tag, "_in_ready"}, in_ready[sel], 1);
        check({tag, "_out_valid"}, out_valid[sel], 0);
        check({tag, "_f_start"}, f_start[sel], 0);
        check({tag, "_busy"}, busy[sel], 0);
        check({tag, "_out_lr"}, out_lr[sel], 0);
        check({tag, "_round"}, round[sel], 0);
        check({tag, "_f_r"}, f_r[sel], 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] key, pt, ct, res, lr;
        logic [55:0] cd;
        int          sel;
        key = 64'h133457799BBCDFF1;
        pt  = 64'h0123456789ABCDEF;
        ct  = 64'h85E813540F0AB405;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]   = 1'b0;
            in_decrypt[i] = 1'b0;
            in_lr[i]      = '0;
            in_cd[i]      = '0;
            out_ready[i]  = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst0", 0);
        check_reset_state("rst1", 1);
        rst_n = 1'b1;

        // FIPS known answer, encrypt then decrypt, F_LATENCY=0.
        run_job(0, ip_perm(pt), pc1_perm(key), 1'b0, 0, res);
        check("fips_ct", fp_perm(res), ct);
        run_job(0, ip_perm(ct), pc1_perm(key), 1'b1, 3, res);
        check("fips_pt", fp_perm(res), pt);

        // Same vector on the F_LATENCY=2 instance, with 10 cycles of backpressure.
        run_job(1, ip_perm(pt), pc1_perm(key), 1'b0, 10, res);
        check("fips_ct_lat2", fp_perm(res), ct);

        // Randomized jobs on both instances.
        for (int i = 0; i < 10; i++) begin
            sel = int'($urandom_range(1, 0));
            lr  = {$urandom, $urandom};
            cd  = 56'({$urandom, $urandom});
            run_job(sel, lr, cd, 1'($urandom), int'($urandom_range(3, 0)), res);
        end

        // Back-to-back jobs.
        run_b2b(0);
        run_b2b(1);

        // Reset in the middle of round 7, then a fresh job.
        @(negedge clk);
        in_valid[0]   = 1'b1;
        in_lr[0]      = ip_perm(pt);
        in_cd[0]      = pc1_perm(key);
        in_decrypt[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        for (int i = 0; i < 40 && round[0] != 4'd7; i++) @(negedge clk);
        check("reached_round7", round[0], 7);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midrst", 0);
        repeat (2) @(negedge clk);
        check("midrst_no_out_valid", out_valid[0], 0);
        rst_n = 1'b1;
        run_job(0, ip_perm(pt), pc1_perm(key), 1'b0, 1, res);
        check("fips_ct_after_reset", fp_perm(res), ct);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
